// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and sizing helpers for systolic blocks
package systolic_pkg;

   typedef logic [1:0] sys_state_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Serial-bit counter width for a 2W-cycle run.
   function automatic int sys_cnt_width(input int word_width);
      return $clog2(2 * word_width);
   endfunction

endpackage

// File: rtl/systolic_acc_cell.sv
// rtl/systolic_acc_cell.sv - one bit of the serial-parallel accumulator array
module systolic_acc_cell (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   input  logic weight,
   input  logic mcand_bit,
   input  logic sum_in,
   output logic sum
);

   logic       carry;
   logic [1:0] total;

   assign total = {1'b0, weight & mcand_bit} + {1'b0, sum_in} + {1'b0, carry};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum   <= 1'b0;
         carry <= 1'b0;
      end else if (clear) begin
         sum   <= 1'b0;
         carry <= 1'b0;
      end else if (en) begin
         sum   <= total[0];
         carry <= total[1];
      end
   end

endmodule

// File: rtl/systolic_serial_multiplier.sv
// rtl/systolic_serial_multiplier.sv - bit-serial product, LSB-first, from a row of accumulator cells
module systolic_serial_multiplier
   import systolic_pkg::*;
#(
   parameter int p_WORD_WIDTH = 4,
   parameter int p_SIGNED     = 0
) (
   input  logic                      i_CLK,
   input  logic                      i_RST,
   input  logic                      i_START,
   input  logic [p_WORD_WIDTH-1:0]   i_MULTIPLIER,
   input  logic [p_WORD_WIDTH-1:0]   i_MULTIPLICAND,
   output logic                      o_READY,
   output logic                      o_BIT,
   output logic                      o_BIT_VALID,
   output logic                      o_DONE,
   output logic [2*p_WORD_WIDTH-1:0] o_PRODUCT
);

   localparam int W  = p_WORD_WIDTH;
   localparam int CW = sys_cnt_width(W);
   localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

   sys_state_t       state;
   logic [CW-1:0]    cnt;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_sh;
   logic [W-1:0]     a_mag;
   logic [W-1:0]     b_mag;
   logic [W-1:0]     sum_q;
   logic [W-1:0]     sum_in;
   logic [2*W-1:0]   prod_q;
   logic             neg_q;
   logic             valid_q;
   logic             seen_q;
   logic             accept;
   logic             run;
   logic             out_bit;

   assign accept = (state == ST_IDLE) && i_START;
   assign run    = (state == ST_RUN);

   // -2^(W-1) negates to itself, which is the correct magnitude read as unsigned.
   assign a_mag = ((p_SIGNED != 0) && i_MULTIPLIER[W-1])   ? -i_MULTIPLIER   : i_MULTIPLIER;
   assign b_mag = ((p_SIGNED != 0) && i_MULTIPLICAND[W-1]) ? -i_MULTIPLICAND : i_MULTIPLICAND;

   assign sum_in = {1'b0, sum_q[W-1:1]};

   for (genvar i = 0; i < W; i++) begin : g_cell
      systolic_acc_cell u_cell (
         .clk       (i_CLK),
         .rst       (i_RST),
         .clear     (accept),
         .en        (run),
         .weight    (a_q[i]),
         .mcand_bit (b_sh[0]),
         .sum_in    (sum_in[i]),
         .sum       (sum_q[i])
      );
   end

   // Cell 0 holds the raw product bit; two's-complement negation passes bits up to the first 1 and inverts after.
   assign out_bit = valid_q & (sum_q[0] ^ (neg_q & seen_q));

   assign o_READY     = (state == ST_IDLE);
   assign o_DONE      = (state == ST_DONE);
   assign o_BIT       = out_bit;
   assign o_BIT_VALID = valid_q;
   assign o_PRODUCT   = (state == ST_DONE) ? {out_bit, prod_q[2*W-1:1]} : prod_q;

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         a_q     <= '0;
         b_sh    <= '0;
         neg_q   <= 1'b0;
         valid_q <= 1'b0;
         seen_q  <= 1'b0;
         prod_q  <= '0;
      end else begin
         valid_q <= run;
         if (valid_q) begin
            seen_q <= seen_q | sum_q[0];
            prod_q <= {out_bit, prod_q[2*W-1:1]};
         end
         case (state)
            ST_IDLE: begin
               if (i_START) begin
                  state  <= ST_RUN;
                  cnt    <= '0;
                  a_q    <= a_mag;
                  b_sh   <= b_mag;
                  neg_q  <= (p_SIGNED != 0) && (i_MULTIPLIER[W-1] ^ i_MULTIPLICAND[W-1]);
                  seen_q <= 1'b0;
                  prod_q <= '0;
               end
            end
            ST_RUN: begin
               cnt  <= cnt + CW'(1);
               b_sh <= b_sh >> 1;
               if (cnt == LAST) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_serial_multiplier.sv
// tb/tb_systolic_serial_multiplier.sv - directed vectors for unsigned/signed W=4 and unsigned W=8 multipliers
module tb_systolic_serial_multiplier;

   typedef struct {
      int          sel;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
      bit          poke;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] start = 3'b000;
   logic [3:0] a_u4 = '0, b_u4 = '0, a_s4 = '0, b_s4 = '0;
   logic [7:0] a_u8 = '0, b_u8 = '0;
   logic [2:0] ready, obit, ovalid, odone;
   logic [7:0] prod_u4, prod_s4;
   logic [15:0] prod_u8;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t vecs[15];

   always #5 clk = ~clk;

   systolic_serial_multiplier #(.p_WORD_WIDTH(4), .p_SIGNED(0)) u_u4 (
      .i_CLK(clk), .i_RST(rst), .i_START(start[0]), .i_MULTIPLIER(a_u4), .i_MULTIPLICAND(b_u4),
      .o_READY(ready[0]), .o_BIT(obit[0]), .o_BIT_VALID(ovalid[0]), .o_DONE(odone[0]), .o_PRODUCT(prod_u4));

   systolic_serial_multiplier #(.p_WORD_WIDTH(4), .p_SIGNED(1)) u_s4 (
      .i_CLK(clk), .i_RST(rst), .i_START(start[1]), .i_MULTIPLIER(a_s4), .i_MULTIPLICAND(b_s4),
      .o_READY(ready[1]), .o_BIT(obit[1]), .o_BIT_VALID(ovalid[1]), .o_DONE(odone[1]), .o_PRODUCT(prod_s4));

   systolic_serial_multiplier #(.p_WORD_WIDTH(8), .p_SIGNED(0)) u_u8 (
      .i_CLK(clk), .i_RST(rst), .i_START(start[2]), .i_MULTIPLIER(a_u8), .i_MULTIPLICAND(b_u8),
      .o_READY(ready[2]), .o_BIT(obit[2]), .o_BIT_VALID(ovalid[2]), .o_DONE(odone[2]), .o_PRODUCT(prod_u8));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic set_in(input int sel, input logic s, input logic [7:0] a, input logic [7:0] b);
      case (sel)
         0: begin start[0] = s; a_u4 = a[3:0]; b_u4 = b[3:0]; end
         1: begin start[1] = s; a_s4 = a[3:0]; b_s4 = b[3:0]; end
         default: begin start[2] = s; a_u8 = a; b_u8 = b; end
      endcase
   endtask

   function automatic logic [15:0] get_prod(input int sel);
      case (sel)
         0:       return {8'h00, prod_u4};
         1:       return {8'h00, prod_s4};
         default: return prod_u8;
      endcase
   endfunction

   // Starts at the current time, returns at the first sample where o_READY is high again.
   task automatic run_op(input int idx, input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] expp, input bit poke);
      int          w;
      int          nvalid, ndone, done_at, nbusy;
      logic [31:0] vmask, emask;
      logic [15:0] stream, pdone;
      w = (sel == 2) ? 8 : 4;
      nvalid = 0; ndone = 0; done_at = -1; nbusy = 0;
      vmask = '0; stream = '0; pdone = '0;
      check($sformatf("v%0d ready_at_start", idx), 32'(ready[sel]), 32'd1);
      set_in(sel, 1'b1, a, b);
      @(posedge clk);
      for (int i = 0; i <= 2 * w + 1; i++) begin
         @(negedge clk);
         if (!ready[sel]) nbusy++;
         if (ovalid[sel]) begin
            vmask[i] = 1'b1;
            if (nvalid < 16) stream[nvalid] = obit[sel];
            nvalid++;
         end
         if (odone[sel]) begin
            ndone++;
            done_at = i;
            pdone = get_prod(sel);
         end
         if (i < 2 * w)
            set_in(sel, poke ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom), 8'($urandom));
         else if (i == 2 * w)
            set_in(sel, poke, 8'($urandom), 8'($urandom));
         else
            set_in(sel, 1'b0, a, b);
      end
      emask = ((32'd1 << (2 * w)) - 32'd1) << 1;
      check($sformatf("v%0d valid_window", idx), vmask, emask);
      check($sformatf("v%0d bit_stream", idx), 32'(stream), 32'(expp));
      check($sformatf("v%0d done_count", idx), 32'(ndone), 32'd1);
      check($sformatf("v%0d done_cycle", idx), 32'(done_at), 32'(2 * w));
      check($sformatf("v%0d busy_cycles", idx), 32'(nbusy), 32'(2 * w + 1));
      check($sformatf("v%0d product_at_done", idx), 32'(pdone), 32'(expp));
      check($sformatf("v%0d product_held", idx), 32'(get_prod(sel)), 32'(expp));
   endtask

   initial begin
      vecs[0]  = '{0, 8'd13,  8'd11,  16'h008F, 1'b0};
      vecs[1]  = '{0, 8'd15,  8'd15,  16'h00E1, 1'b0};
      vecs[2]  = '{0, 8'd0,   8'd9,   16'h0000, 1'b0};
      vecs[3]  = '{0, 8'd10,  8'd6,   16'h003C, 1'b1};
      vecs[4]  = '{0, 8'd13,  8'd11,  16'h008F, 1'b1};
      vecs[5]  = '{1, 8'hD,   8'h5,   16'h00F1, 1'b0};
      vecs[6]  = '{1, 8'h8,   8'h8,   16'h0040, 1'b0};
      vecs[7]  = '{1, 8'h7,   8'h8,   16'h00C8, 1'b0};
      vecs[8]  = '{1, 8'hF,   8'hF,   16'h0001, 1'b0};
      vecs[9]  = '{1, 8'h0,   8'hB,   16'h0000, 1'b0};
      vecs[10] = '{1, 8'h3,   8'hC,   16'h00F4, 1'b1};
      vecs[11] = '{1, 8'hA,   8'hD,   16'h0012, 1'b0};
      vecs[12] = '{2, 8'd255, 8'd255, 16'hFE01, 1'b1};
      vecs[13] = '{2, 8'd200, 8'd100, 16'h4E20, 1'b0};
      vecs[14] = '{2, 8'h80,  8'h02,  16'h0100, 1'b0};

      #1 rst = 1'b1;
      #1;
      check("reset ready", 32'(ready), 32'h7);
      check("reset bit", 32'(obit), 32'h0);
      check("reset valid", 32'(ovalid), 32'h0);
      check("reset done", 32'(odone), 32'h0);
      check("reset product", {8'h00, prod_u4, prod_s4, 8'h00} | 32'(prod_u8), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 15; v++)
         run_op(v, vecs[v].sel, vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].poke);

      // Abort a W=4 run between E3 and E4, then start on the first edge after release.
      @(negedge clk);
      set_in(0, 1'b1, 8'd13, 8'd11);
      @(posedge clk);
      #1 set_in(0, 1'b0, 8'd0, 8'd0);
      repeat (3) @(posedge clk);
      #2;
      check("pre_reset valid", 32'(ovalid[0]), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_reset ready", 32'(ready[0]), 32'd1);
      check("mid_reset bit", 32'(obit[0]), 32'd0);
      check("mid_reset valid", 32'(ovalid[0]), 32'd0);
      check("mid_reset done", 32'(odone[0]), 32'd0);
      check("mid_reset product", 32'(prod_u4), 32'd0);
      #1 rst = 1'b0;
      run_op(15, 0, 8'd2, 8'd3, 16'h0006, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
